// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl
// ---------------
// Scrolling hex message display for a six-digit seven-segment board.
// Hex digits are entered one at a time from the switches into a 16-entry
// message buffer. Once the message is longer than the six displays, it can
// be scrolled right-to-left and wraps around. Scrolling can be paused and
// resumed, and the message can be cleared.
//
// Parameters
//   TICK_DIV  clock cycles per scroll step (>= 2)
//
// Ports
//   CLOCK_50     in   1   system clock, rising edge
//   Resetn       in   1   synchronous active-low reset
//   SW[9:0]      in  10   SW[3:0] = digit to write, SW[9:4] unused
//   KEY[3:0]     in   4   active-low buttons: [1] write, [2] run/pause,
//                         [3] clear, [0] unused
//   HEX5..HEX0   out  7   active-low segments (bit0 = a ... bit6 = g),
//                         HEX5 is the leftmost digit
//   LEDR[9:0]    out 10   [4:0] len, [5] running, [6] full, [9:7] zero

module hex_scroll_ctrl #(
    parameter int TICK_DIV = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [9:0] SW,
    input  logic [3:0] KEY,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAUSED = 2'd1,
        RUN    = 2'd2
    } state_t;

    logic [3:0] key_meta;
    logic [3:0] key_sync;
    logic [3:0] key_prev;
    logic [3:0] key_armed;
    logic [1:0] sync_fill;
    logic [3:0] press;

    logic wr_press;
    logic run_press;
    logic clr_press;

    state_t           state;
    state_t           state_n;
    logic [4:0]       len;
    logic [4:0]       len_n;
    logic [3:0]       pos;
    logic [3:0]       pos_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             buf_we;
    logic             full;

    logic [3:0] msg_buf [16];
    logic [6:0] seg_next [6];

    logic unused_inputs;

    // Key synchronizers and falling-edge detectors. The synchronizers reset
    // to the released level. A key is only armed once its synchronized level
    // has been seen high with real (post-reset) data in the pipeline, so a
    // button held down across reset release cannot masquerade as a press.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            key_meta  <= 4'hF;
            key_sync  <= 4'hF;
            key_prev  <= 4'hF;
            key_armed <= 4'h0;
            sync_fill <= 2'b00;
        end else begin
            key_meta  <= KEY;
            key_sync  <= key_meta;
            key_prev  <= key_sync;
            sync_fill <= {sync_fill[0], 1'b1};
            key_armed <= key_armed | ({4{sync_fill[1]}} & key_sync);
        end
    end

    assign press     = key_armed & key_prev & ~key_sync;
    assign wr_press  = press[1];
    assign run_press = press[2];
    assign clr_press = press[3];
    assign full      = (len == 5'd16);

    assign unused_inputs = ^{SW[9:4], press[0]};

    // Control state register.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state <= IDLE;
            len   <= '0;
            pos   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            len   <= len_n;
            pos   <= pos_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic. Clear beats everything; a write beats a run press
    // arriving in the same cycle, and the losing press is simply dropped.
    // Pausing freezes both the tick counter and the scroll position.
    always_comb begin
        state_n = state;
        len_n   = len;
        pos_n   = pos;
        cnt_n   = cnt;
        buf_we  = 1'b0;

        if (clr_press) begin
            state_n = IDLE;
            len_n   = '0;
            pos_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_press) begin
                        buf_we  = 1'b1;
                        len_n   = 5'd1;
                        state_n = PAUSED;
                    end
                end
                PAUSED: begin
                    if (wr_press) begin
                        if (!full) begin
                            buf_we = 1'b1;
                            len_n  = len + 5'd1;
                        end
                    end else if (run_press && (len > 5'd6)) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end
                end
                RUN: begin
                    if (run_press && !wr_press) begin
                        state_n = PAUSED;
                    end else if (cnt == CNT_LAST) begin
                        cnt_n = '0;
                        pos_n = (({1'b0, pos} + 5'd1) == len) ? 4'd0 : pos + 4'd1;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    len_n   = '0;
                    pos_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Message storage. Deliberately not reset: entries at or beyond len are
    // never displayed, so stale contents are harmless.
    always_ff @(posedge CLOCK_50) begin
        if (Resetn && buf_we) begin
            msg_buf[len[3:0]] <= SW[3:0];
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // (p + k) mod n; p < n and k <= 5 < n whenever scrolling is possible,
    // so a single conditional subtraction is enough.
    function automatic logic [3:0] view_index(input logic [3:0] p,
                                              input logic [4:0] n,
                                              input logic [2:0] k);
        logic [4:0] sum;
        sum = {1'b0, p} + {2'b0, k};
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum[3:0];
    endfunction

    // Display window: slot k (0 = leftmost) shows the message rotated by pos
    // when the message is longer than the window, otherwise the first len
    // digits followed by blanks. len = 0 therefore blanks everything.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            seg_next[k] = 7'h7F;
            if ((len > 5'd6) || (5'(k) < len)) begin
                seg_next[k] = seg7(msg_buf[view_index(pos, len, 3'(k))]);
            end
        end
    end

    // Output registers; they follow the control state by one cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            HEX5 <= 7'h7F;
            HEX4 <= 7'h7F;
            HEX3 <= 7'h7F;
            HEX2 <= 7'h7F;
            HEX1 <= 7'h7F;
            HEX0 <= 7'h7F;
            LEDR <= '0;
        end else begin
            HEX5 <= seg_next[0];
            HEX4 <= seg_next[1];
            HEX3 <= seg_next[2];
            HEX2 <= seg_next[3];
            HEX1 <= seg_next[4];
            HEX0 <= seg_next[5];
            LEDR <= {3'b000, full, (state == RUN), len};
        end
    end

endmodule
